// File: rtl/ffd_pkg.sv
// Shared constants for the FFD enable strobe generator: FSM encoding, mode
// encoding and default widths.
package ffd_pkg;

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_RUN     = 1'b1;

   localparam logic       MODE_CONT  = 1'b0;
   localparam logic       MODE_BURST = 1'b1;

   localparam int         DEF_DIV_W  = 8;
   localparam int         DEF_CNT_W  = 8;

endpackage

// File: rtl/ffd_enable_gen_if.sv
// Control/status bundle between the pacing controller and ffd_enable_gen.
interface ffd_enable_gen_if #(
   parameter int DIV_W = 8,
   parameter int CNT_W = 8
) ();

   logic             start;
   logic             stop;
   logic             mode;
   logic [DIV_W-1:0] div;
   logic [CNT_W-1:0] burst_len;
   logic             enable;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] pulse_cnt;

   modport master (
      output start, stop, mode, div, burst_len,
      input  enable, busy, done, pulse_cnt
   );

   modport slave (
      input  start, stop, mode, div, burst_len,
      output enable, busy, done, pulse_cnt
   );

endinterface

// File: rtl/ffd_enable_gen_cnt.sv
// Loadable down-counter with zero flag; times the gap between enable strobes.
module ffd_enable_gen_cnt #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             dec,
   input  logic [DIV_W-1:0] load_val,
   output logic [DIV_W-1:0] count,
   output logic             zero
);

   logic [DIV_W-1:0] count_d;
   logic [DIV_W-1:0] count_q;

   // Load takes priority; decrement never runs below zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/ffd_enable_gen.sv
// Enable strobe generator for the FFD stage: programmable period, continuous
// or fixed-length burst, all outputs registered.
module ffd_enable_gen
   import ffd_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   ffd_enable_gen_if.slave   bus
);

   logic [0:0]       state_d,     state_q;
   logic [DIV_W-1:0] div_d,       div_q;
   logic [CNT_W-1:0] blen_d,      blen_q;
   logic             mode_d,      mode_q;
   logic             enable_d,    enable_q;
   logic             busy_d,      busy_q;
   logic             done_d,      done_q;
   logic [CNT_W-1:0] pulse_cnt_d, pulse_cnt_q;

   logic             cnt_load;
   logic             cnt_dec;
   logic [DIV_W-1:0] cnt_load_val;
   logic [DIV_W-1:0] cnt_count;
   logic             cnt_zero;

   logic [DIV_W-1:0] div_eff;
   logic [CNT_W-1:0] blen_eff;
   logic [CNT_W:0]   issued;
   logic             last_strobe;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // A zero period or burst length behaves as one.
   assign div_eff     = (bus.div == '0)       ? DIV_W'(1) : bus.div;
   assign blen_eff    = (bus.burst_len == '0) ? CNT_W'(1) : bus.burst_len;
   assign issued      = {1'b0, pulse_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
   assign last_strobe = (issued == {1'b0, blen_q});

   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      blen_d       = blen_q;
      mode_d       = mode_q;
      enable_d     = 1'b0;
      done_d       = 1'b0;
      busy_d       = busy_q;
      pulse_cnt_d  = pulse_cnt_q;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      cnt_load_val = div_q - DIV_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.stop) begin
               state_d      = ST_RUN;
               div_d        = div_eff;
               blen_d       = blen_eff;
               mode_d       = bus.mode;
               cnt_load     = 1'b1;
               cnt_load_val = div_eff - DIV_W'(1);
               pulse_cnt_d  = '0;
               busy_d       = 1'b1;
            end
         end
         default: begin
            // Stop wins even over a strobe that is due on this edge.
            if (bus.stop) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else if (cnt_zero) begin
               enable_d    = 1'b1;
               pulse_cnt_d = sat_inc(pulse_cnt_q);
               if ((mode_q == MODE_BURST) && last_strobe) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  cnt_load = 1'b1;
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         div_q       <= '0;
         blen_q      <= '0;
         mode_q      <= 1'b0;
         enable_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pulse_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         blen_q      <= blen_d;
         mode_q      <= mode_d;
         enable_q    <= enable_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pulse_cnt_q <= pulse_cnt_d;
      end
   end

   ffd_enable_gen_cnt #(
      .DIV_W (DIV_W)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (cnt_load_val),
      .count    (cnt_count),
      .zero     (cnt_zero)
   );

   assign bus.enable    = enable_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_ffd_enable_gen.sv
// Directed bench for ffd_enable_gen, including a downstream enabled flip-flop.
module tb_ffd_enable_gen;

   logic clk = 1'b0;
   logic reset;
   logic ffd_q;
   int   checks = 0;
   int   errors = 0;

   ffd_enable_gen_if #(.DIV_W(8), .CNT_W(8)) bus ();

   ffd_enable_gen #(
      .DIV_W (8),
      .CNT_W (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Downstream FFD with its data input tied high.
   always @(posedge clk) begin
      if (!reset)          ffd_q <= 1'b0;
      else if (bus.enable) ffd_q <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_enable"}, 32'(bus.enable), 0);
      check({tag, "_busy"},   32'(bus.busy),   0);
      check({tag, "_done"},   32'(bus.done),   0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset         = 1'b0;
      bus.start     = 1'b1;
      bus.stop      = 1'b0;
      bus.mode      = 1'b0;
      bus.div       = 8'd4;
      bus.burst_len = 8'd0;

      // Reset held with start asserted
      repeat (3) step();
      check_idle("rst");
      check("rst_cnt", 32'(bus.pulse_cnt), 0);
      bus.start = 1'b0;
      reset     = 1'b1;
      repeat (2) step();
      check_idle("rel");
      check("rel_cnt", 32'(bus.pulse_cnt), 0);

      // start and stop together in IDLE
      bus.start = 1'b1; bus.stop = 1'b1;
      step();
      bus.start = 1'b0; bus.stop = 1'b0;
      check_idle("ss");

      // Continuous, div=4; start re-pulsed mid-run with a new div is ignored
      bus.div = 8'd4; bus.mode = 1'b0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("c4_busy0", 32'(bus.busy), 1);
      check("c4_en0", 32'(bus.enable), 0);
      for (int k = 1; k <= 12; k++) begin
         if (k == 5) begin bus.start = 1'b1; bus.div = 8'd9; end
         if (k == 6) begin bus.start = 1'b0; bus.div = 8'd4; end
         step();
         check($sformatf("c4_en%0d", k), 32'(bus.enable), (k % 4 == 0) ? 1 : 0);
         check($sformatf("c4_busy%0d", k), 32'(bus.busy), 1);
      end
      check("c4_cnt", 32'(bus.pulse_cnt), 3);
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      check("c4_stop_busy", 32'(bus.busy), 0);

      // Burst of 2, div=3
      bus.div = 8'd3; bus.burst_len = 8'd2; bus.mode = 1'b1; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         step();
         check($sformatf("b3_en%0d", k), 32'(bus.enable), (k % 3 == 0) ? 1 : 0);
         check($sformatf("b3_done%0d", k), 32'(bus.done), (k == 6) ? 1 : 0);
         check($sformatf("b3_busy%0d", k), 32'(bus.busy), (k == 6) ? 0 : 1);
      end
      check("b3_cnt", 32'(bus.pulse_cnt), 2);
      for (int k = 1; k <= 6; k++) begin
         step();
         check($sformatf("b3_after_en%0d", k), 32'(bus.enable), 0);
      end
      check("b3_cnt_hold", 32'(bus.pulse_cnt), 2);

      // div=0, burst_len=0 behave as 1
      bus.div = 8'd0; bus.burst_len = 8'd0; bus.mode = 1'b1; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      check("z_en", 32'(bus.enable), 1);
      check("z_done", 32'(bus.done), 1);
      check("z_busy", 32'(bus.busy), 0);
      check("z_cnt", 32'(bus.pulse_cnt), 1);
      step();
      check("z_en_next", 32'(bus.enable), 0);
      check("z_done_next", 32'(bus.done), 0);

      // Stop on the edge where the first strobe is due
      bus.div = 8'd5; bus.mode = 1'b0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("s5_en%0d", k), 32'(bus.enable), 0);
      end
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      check_idle("s5");
      check("s5_cnt", 32'(bus.pulse_cnt), 0);
      step();
      check("s5_en_after", 32'(bus.enable), 0);

      // Reset mid-run
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      check("r5_busy_run", 32'(bus.busy), 1);
      reset = 1'b0;
      step();
      reset = 1'b1;
      check_idle("r5");
      check("r5_cnt", 32'(bus.pulse_cnt), 0);

      // Chain into the FFD, div=2; div change mid-run must not alter the period
      bus.div = 8'd2; bus.mode = 1'b0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("f_q0", 32'(ffd_q), 0);
      for (int k = 1; k <= 10; k++) begin
         if (k == 2) bus.div = 8'd7;
         step();
         check($sformatf("f_en%0d", k), 32'(bus.enable), (k % 2 == 0) ? 1 : 0);
         check($sformatf("f_q%0d", k), 32'(ffd_q), (k >= 3) ? 1 : 0);
      end
      check("f_cnt", 32'(bus.pulse_cnt), 5);
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;

      // Saturation with div=1: enable every cycle, pulse_cnt pins at 255
      bus.div = 8'd1; bus.mode = 1'b0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      check("sat_en1", 32'(bus.enable), 1);
      step();
      check("sat_en2", 32'(bus.enable), 1);
      check("sat_cnt2", 32'(bus.pulse_cnt), 2);
      repeat (298) step();
      check("sat_cnt", 32'(bus.pulse_cnt), 255);
      check("sat_en", 32'(bus.enable), 1);
      check("sat_busy", 32'(bus.busy), 1);
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      check("sat_stop_cnt", 32'(bus.pulse_cnt), 255);
      check_idle("sat_stop");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ffd_enable_gen.md
Name: ffd_enable_gen

Overview:
- Upstream pacing stage for the enabled D flip-flop (FFD) stage.
- Generates the single-cycle `enable` strobe that the flip-flop's enable input consumes.
- Programmable period; runs continuously or for a fixed burst of pulses.
- Replaces hand-timed enable toggling with a clocked, deterministic strobe source.

Parameters:
- DIV_W, 8, width of the period input `div`.
- CNT_W, 8, width of the `pulse_cnt` output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- start  input  1  level-sampled request to begin generation; latches div, burst_len, mode.
- stop  input  1  level-sampled request to abort generation.
- mode  input  1  0 = continuous, 1 = burst.
- div  input  DIV_W  enable period in clk cycles; 0 is treated as 1.
- burst_len  input  CNT_W  pulses per burst (mode=1); 0 is treated as 1.
- enable  output  1  one-cycle strobe to the FFD enable input.
- busy  output  1  high while generating.
- done  output  1  one-cycle pulse coincident with the final burst strobe.
- pulse_cnt  output  CNT_W  strobes issued since last start; saturates at all-ones.

Behaviour:
- Reset (reset=0 at an edge): state IDLE; enable=0, busy=0, done=0, pulse_cnt=0, period counter=0, latched config=0. Reset has priority over every other input, including mid-run.
- All outputs are registered; no combinational path from input to output.
- States: IDLE, RUN.
- IDLE -> RUN: start=1 and stop=0 at edge E0.
  - At E0: latch D=max(div,1), B=max(burst_len,1), mode.
  - At E0: load counter with D-1, clear pulse_cnt, set busy=1.
- RUN, each edge:
  - If stop=1: go IDLE, enable=0, busy=0, done=0; pulse_cnt holds. Stop beats a due strobe.
  - Else if counter==0: enable=1, reload D-1, pulse_cnt+1 (saturating).
  - Else: counter-1, enable=0.
- Strobe timing: first enable is high in the cycle after edge E0+D; thereafter every D cycles. D=1 gives enable high every cycle.
- Burst (mode=1): on the edge issuing strobe number B, assert done=1 for that one cycle, go IDLE, busy=0 at the same edge. The counter does not reload.
- Continuous (mode=0): runs until stop or reset. pulse_cnt saturates; it does not wrap, and strobes continue.
- start while RUN: ignored; config is not relatched.
- start and stop both high in IDLE: stop wins, remain IDLE.
- div and burst_len changes during RUN have no effect until the next start.
- enable and done are never high for more than one consecutive cycle, except enable when D=1.

Decomposition:
- Shared package ffd_pkg:
  - state encoding (ST_IDLE=1'b0, ST_RUN=1'b1);
  - mode constants MODE_CONT=1'b0, MODE_BURST=1'b1;
  - default widths.
- One natural sub-module, ffd_enable_gen_cnt: loadable down-counter with load value, decrement, and zero flag, width DIV_W. The FSM and pulse_cnt stay in the top.

Test Plan:
- Reset=0 for 3 edges with start=1 -> enable, busy, done, pulse_cnt all 0. Release reset with start=0 -> outputs stay 0.
- div=4, mode=0, start pulse at E0 -> enable high after edges E0+4, E0+8, E0+12, one cycle each. pulse_cnt=3 after E0+12. busy=1 throughout.
- div=3, burst_len=2, mode=1 -> enable after E0+3 and E0+6. done=1 with the second strobe. busy=0 after E0+6. pulse_cnt holds 2. No further strobes.
- div=0 and burst_len=0, mode=1 -> single strobe after E0+1, with done in the same cycle (both treated as 1).
- div=5, mode=0; stop=1 at E0+5 (strobe due) -> enable stays 0, state IDLE, pulse_cnt=0. Repeat with reset=0 at E0+2 -> all outputs 0 next cycle.
- Chain into FFD with D=1, div=2: Q captures D only on edges where enable=1. Changing div to 7 mid-run leaves the period at 2.
